// File: rtl/axi4_lite_reg_file.sv
// AXI4-Lite slave register file with per-register write enable and reset value.
// Write commits honour WSTRB byte lanes. An out-of-range address returns SLVERR.
// Each committed write to a writable register raises a one-cycle strobe.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   reg_val            current register contents, reg i at reg_val[i]
//   reg_in             captured every cycle into read-only registers
//   reg_wr_pulse       one-cycle strobe per register on an AXI write commit
//   s_axi_aw*/w*/b*    AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*       AXI4-Lite read address and data channels
module axi4_lite_reg_file #(
  parameter int unsigned                       num_regs     = 4,
  parameter int unsigned                       addr_width   = 7,
  parameter int unsigned                       data_width   = 32,
  parameter logic [num_regs-1:0]               allow_write  = {num_regs{1'b1}},
  parameter logic [num_regs*data_width-1:0]    reset_values = {num_regs*data_width{1'b0}}
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic [num_regs-1:0][data_width-1:0]  reg_val,
  input  logic [num_regs-1:0][data_width-1:0]  reg_in,
  output logic [num_regs-1:0]                  reg_wr_pulse,
  input  logic [addr_width-1:0]                s_axi_awaddr,
  input  logic [2:0]                           s_axi_awprot,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [data_width-1:0]                s_axi_wdata,
  input  logic [data_width/8-1:0]              s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [addr_width-1:0]                s_axi_araddr,
  input  logic [2:0]                           s_axi_arprot,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [data_width-1:0]                s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready
);

  localparam int unsigned strb_width = data_width / 8;
  localparam int unsigned lsb        = $clog2(strb_width);
  localparam int unsigned idx_width  = addr_width - lsb;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  // Write path state
  w_state_t                  w_state_q, w_state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [idx_width-1:0]      aw_idx_q, aw_idx_d;
  logic [data_width-1:0]     w_data_q, w_data_d;
  logic [strb_width-1:0]     w_strb_q, w_strb_d;
  logic                      awready_d, wready_d, bvalid_d;
  logic [1:0]                bresp_d;
  logic                      commit_c;
  logic                      wr_in_range_c;

  // Register array next state
  logic [num_regs-1:0][data_width-1:0] reg_val_d;
  logic [num_regs-1:0]                 reg_wr_pulse_d;

  // Read path state
  r_state_t                  r_state_q, r_state_d;
  logic                      arready_d, rvalid_d;
  logic [1:0]                rresp_d;
  logic [data_width-1:0]     rdata_d;
  logic [idx_width-1:0]      rd_idx_c;
  logic                      rd_in_range_c;

  // Protection bits and byte-offset address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[lsb-1:0], s_axi_araddr[lsb-1:0], reg_in};

  assign wr_in_range_c = 32'(aw_idx_q) < num_regs;
  assign rd_idx_c      = s_axi_araddr[addr_width-1:lsb];
  assign rd_in_range_c = 32'(rd_idx_c) < num_regs;

  // Write FSM: collect AW and W independently, commit on the edge after both are held
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    awready_d = s_axi_awready;
    wready_d  = s_axi_wready;
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    commit_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_awready) begin
          aw_done_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[addr_width-1:lsb];
          awready_d = 1'b0;
        end else if (!aw_done_q) begin
          awready_d = 1'b1;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_done_d = 1'b1;
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb;
          wready_d = 1'b0;
        end else if (!w_done_q) begin
          wready_d = 1'b1;
        end
        if (aw_done_q && w_done_q) begin
          commit_c  = 1'b1;
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Register update: read-only regs track reg_in, writable regs merge strobed bytes on commit
  always_comb begin
    reg_val_d      = reg_val;
    reg_wr_pulse_d = '0;
    for (int unsigned i = 0; i < num_regs; i++) begin
      if (!allow_write[i]) begin
        reg_val_d[i] = reg_in[i];
      end else if (commit_c && (32'(aw_idx_q) == i)) begin
        for (int unsigned b = 0; b < strb_width; b++) begin
          reg_val_d[i][b*8 +: 8] = w_strb_q[b] ? w_data_q[b*8 +: 8] : reg_val[i][b*8 +: 8];
        end
        reg_wr_pulse_d[i] = |w_strb_q;
      end
    end
  end

  // Read FSM: sample the registered contents at the AR handshake edge
  always_comb begin
    r_state_d = r_state_q;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rresp_d   = s_axi_rresp;
    rdata_d   = s_axi_rdata;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && s_axi_arready) begin
          r_state_d = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
          rdata_d   = '0;
          for (int unsigned i = 0; i < num_regs; i++) begin
            if (32'(rd_idx_c) == i) rdata_d = reg_val[i];
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q     <= W_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      reg_wr_pulse  <= '0;
      for (int unsigned i = 0; i < num_regs; i++) begin
        reg_val[i] <= allow_write[i] ? reset_values[i*data_width +: data_width] : '0;
      end
      r_state_q     <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
    end else begin
      w_state_q     <= w_state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      aw_idx_q      <= aw_idx_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      reg_wr_pulse  <= reg_wr_pulse_d;
      reg_val       <= reg_val_d;
      r_state_q     <= r_state_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rresp   <= rresp_d;
      s_axi_rdata   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// Directed bench for axi4_lite_reg_file: 4 x 32-bit regs, reg2 read-only.
module tb_axi4_lite_reg_file;

  logic              clk;
  logic              rst_n;
  logic [3:0][31:0]  reg_val;
  logic [3:0][31:0]  reg_in;
  logic [3:0]        reg_wr_pulse;
  logic [6:0]        awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  int n_checks = 0;
  int n_errors = 0;

  axi4_lite_reg_file #(
    .num_regs     (4),
    .addr_width   (7),
    .data_width   (32),
    .allow_write  (4'b1011),
    .reset_values ({32'h0000_0003, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0000})
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_val       (reg_val),
    .reg_in        (reg_in),
    .reg_wr_pulse  (reg_wr_pulse),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (3'b000),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (3'b000),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AXI write; W is presented w_delay cycles after AW. Returns bresp and the pulse seen with bvalid.
  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_delay, output logic [1:0] resp, output logic [3:0] pulse);
    int cyc;
    bit aw_pend, w_pend, w_started, aw_hs, w_hs;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1;
    w_started = (w_delay == 0);
    wvalid = w_started;
    aw_pend = 1'b1; w_pend = 1'b1; cyc = 0;
    while ((aw_pend || w_pend) && cyc < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); cyc++;
      if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin wvalid  = 1'b0; w_pend  = 1'b0; end
      if (!w_started && cyc >= w_delay) begin wvalid = 1'b1; w_started = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accepted", 64'(aw_pend || w_pend), 64'd0);
    cyc = 0;
    while (!bvalid && cyc < 20) begin tick(); cyc++; end
    check("wr_bvalid", 64'(bvalid), 64'd1);
    resp = bresp; pulse = reg_wr_pulse;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit hs;
    araddr = addr; arvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      hs = arvalid && arready;
      tick(); cyc++;
    end
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin tick(); cyc++; end
    check("rd_rvalid", 64'(rvalid), 64'd1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] data;
    bit          ok;
    int          cyc;

    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    reg_in = '0;
    reg_in[2] = 32'h0000_0055;

    // Reset state
    repeat (3) tick();
    check("rst_reg1", 64'(reg_val[1]), 64'hDEAD_BEEF);
    check("rst_reg2_ro_zero", 64'(reg_val[2]), 64'h0);
    check("rst_reg3", 64'(reg_val[3]), 64'h3);
    check("rst_valids", 64'({bvalid, rvalid, reg_wr_pulse}), 64'h0);
    check("rst_readies", 64'({awready, wready, arready}), 64'h0);
    rst_n = 1'b1;
    check("readies_before_edge", 64'({awready, wready, arready}), 64'h0);
    tick();
    check("readies_after_edge", 64'({awready, wready, arready}), 64'h7);

    // AW one cycle ahead of W
    do_write(7'h04, 32'h1234_5678, 4'b1111, 1, resp, pulse);
    check("wr1_bresp", 64'(resp), 64'h0);
    check("wr1_pulse", 64'(pulse), 64'h2);
    check("wr1_pulse_gone", 64'(reg_wr_pulse), 64'h0);
    check("wr1_reg1", 64'(reg_val[1]), 64'h1234_5678);

    // Byte-lane merge
    do_write(7'h04, 32'hAABB_CCDD, 4'b1111, 0, resp, pulse);
    do_write(7'h04, 32'h1122_3344, 4'b0101, 0, resp, pulse);
    check("strb_reg1", 64'(reg_val[1]), 64'hAA22_CC44);
    do_read(7'h04, data, resp);
    check("strb_readback", 64'(data), 64'hAA22_CC44);
    check("strb_rresp", 64'(resp), 64'h0);

    // Read-only register ignores writes and tracks reg_in
    do_write(7'h08, 32'h0000_00FF, 4'b1111, 0, resp, pulse);
    check("ro_bresp", 64'(resp), 64'h0);
    check("ro_pulse", 64'(pulse), 64'h0);
    check("ro_reg2", 64'(reg_val[2]), 64'h55);
    do_read(7'h08, data, resp);
    check("ro_readback", 64'(data), 64'h55);
    reg_in[2] = 32'h0000_0066;
    check("ro_latency_old", 64'(reg_val[2]), 64'h55);
    tick();
    check("ro_latency_new", 64'(reg_val[2]), 64'h66);

    // Out-of-range accesses
    do_read(7'h7C, data, resp);
    check("oor_rresp", 64'(resp), 64'h2);
    check("oor_rdata", 64'(data), 64'h0);
    do_write(7'h7C, 32'hFFFF_FFFF, 4'b1111, 0, resp, pulse);
    check("oor_bresp", 64'(resp), 64'h2);
    check("oor_pulse", 64'(pulse), 64'h0);
    check("oor_regs", 64'({reg_val[3], reg_val[1]}), {32'h3, 32'hAA22_CC44});

    // Zero strobe: OKAY but no pulse and no change
    do_write(7'h00, 32'hFFFF_FFFF, 4'b0000, 0, resp, pulse);
    check("nostrb_bresp", 64'(resp), 64'h0);
    check("nostrb_pulse", 64'(pulse), 64'h0);
    check("nostrb_reg0", 64'(reg_val[0]), 64'h0);

    // Byte-offset bits of the address are ignored
    do_write(7'h0D, 32'hCAFE_0000, 4'b1100, 2, resp, pulse);
    check("offset_pulse", 64'(pulse), 64'h8);
    check("offset_reg3", 64'(reg_val[3]), 64'hCAFE_0003);

    // Write response backpressure
    awaddr = 7'h00; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin tick(); cyc++; end
    check("bp_bvalid", 64'(bvalid), 64'd1);
    awaddr = 7'h04; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick();
      ok &= bvalid && (bresp == 2'b00) && !awready && !wready;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_b_hold", 64'(ok), 64'd1);
    check("bp_regs", 64'({reg_val[1], reg_val[0]}), {32'hAA22_CC44, 32'h0BAD_F00D});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bp_b_done", 64'(bvalid), 64'd0);

    // Read response backpressure
    araddr = 7'h00; arvalid = 1'b1;
    tick();
    araddr = 7'h04;
    ok = rvalid;
    repeat (10) begin
      tick();
      ok &= rvalid && (rdata == 32'h0BAD_F00D) && (rresp == 2'b00) && !arready;
    end
    arvalid = 1'b0;
    check("bp_r_hold", 64'(ok), 64'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("bp_r_done", 64'({rvalid, arready}), 64'h1);

    // Reset with only AW captured drops the write
    awaddr = 7'h00; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    check("midrst_reg0", 64'(reg_val[0]), 64'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    wdata = 32'h1234_5678; wvalid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      tick();
      ok &= !bvalid && (reg_wr_pulse == 4'h0);
    end
    wvalid = 1'b0;
    check("midrst_no_commit", 64'(ok), 64'd1);
    check("midrst_reg0_after", 64'(reg_val[0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
